swizzle_d2c_pingpong: RTL and testbench
=======================================

// Module: swizzle_d2c_pingpong
// PURPOSE
//  Parametrised DRAM-to-compute-RAM swizzle. Takes DWIDTH-bit words from the memory controller and groups them into DWIDTH x DWIDTH tiles.
//  Each tile is written out transposed, one column per cycle, to a CRAM write port.
//  Two tile banks alternate (ping-pong): one loads while the other unloads.
//  New over the previous generation: valid/ready input handshake, CRAM-side stall, run-time base address/RAM number, explicit flush with zero-padding of a partial tile, done/busy status.
// PARAMETERS
//  DWIDTH        40   input word width = output word width = tile rows and columns
//  RAM_AWIDTH    9    CRAM address width
//  RAM_NUM_WORDS 512  words per CRAM; address wraps at RAM_NUM_WORDS-1
//  RAM_NUM_W     16   width of the CRAM index
//  TRANSPOSE     1    1: emit columns (swizzle); 0: emit rows unchanged (bypass mode, same timing)
// PORTS
//  clk            in   1           clock
//  reset          in   1           synchronous, active-high reset
//  start          in   1           one-cycle pulse; latches cfg_*; honoured only in IDLE
//  cfg_base_addr  in   RAM_AWIDTH  first CRAM address
//  cfg_base_num   in   RAM_NUM_W   first CRAM index
//  in_valid       in   1           in_data valid
//  in_ready       out  1           block accepts in_data; handshake = in_valid & in_ready
//  in_data        in   DWIDTH      memory-controller word
//  flush          in   1           one-cycle pulse: end of stream; pad, drain, then done
//  out_stall      in   1           CRAM port busy; unloader holds
//  ram_data_out   out  DWIDTH      write data
//  ram_addr       out  RAM_AWIDTH  write address
//  ram_we         out  1           write enable
//  ram_num        out  RAM_NUM_W   target CRAM index
//  busy           out  1           high in any state except IDLE
//  done           out  1           one-cycle pulse after the final write
// BEHAVIOUR
//  Reset values: in_ready=0, ram_we=0, ram_addr=0, ram_num=0, ram_data_out=0, busy=0, done=0.
//  Reset clears both banks' full flags. Pending data is discarded and no write is issued after reset.
//  FSM: IDLE -start-> RUN -flush-> PAD -> DRAIN -> IDLE.
//   - PAD is skipped if the fill row is 0.
//   - done pulses on the DRAIN->IDLE transition.
//   - start outside IDLE is ignored; flush outside RUN is ignored.
//  Loader:
//   - in_ready = (state==RUN) & !full[load_bank].
//   - Each handshake writes in_data to row fill_row; fill_row increments.
//   - At row DWIDTH-1, full[load_bank] is set and fill_row returns to 0.
//  PAD: writes zeros to one row per cycle, with in_ready=0, until the bank is full (DWIDTH-fill_row cycles).
//  Swap: when full[load_bank] & !full[unload_bank], load_bank and unload_bank exchange in that cycle. A simultaneous handshake is lost and must not occur, because in_ready is already 0.
//  Unloader:
//   - While full[unload_bank] & !out_stall, reads column c; with TRANSPOSE=0 it reads row c instead. Bit r of the output = bit c of row r.
//   - The read is registered to ram_data_out with ram_we=1.
//   - After c==DWIDTH-1, full[unload_bank] clears.
//   - out_stall high: next cycle ram_we=0, and c, ram_addr and ram_data_out hold.
//  Addressing:
//   - The first write uses cfg_base_addr/cfg_base_num; each write advances ram_addr by 1.
//   - ram_addr==RAM_NUM_WORDS-1 -> next 0 and ram_num+1. ram_num wraps modulo 2^RAM_NUM_W.
//  Latency, no stalls: first handshake at cycle t -> write k of that tile has ram_we=1 in cycle t+DWIDTH+1+k.
//  Throughput: 1 word/cycle sustained with no stalls; there are no bubbles at tile boundaries.
//  DRAIN exits when both full flags are 0 and the final ram_we has been issued; done pulses the following cycle.
// STRUCTURE
//  Package swizzle_pkg holds:
//   - state enum (S_IDLE, S_RUN, S_PAD, S_DRAIN)
//   - default parameter constants
//   - localparam ROW_W = $clog2(DWIDTH)
//  Sub-module swizzle_tile_buf: one DWIDTH x DWIDTH flop bank with row write (we, row, data) and combinational row/column read port selected by TRANSPOSE.
//  The top instantiates two of them, plus the FSM, full flags, counters and output register.
// TESTING
//  1. DWIDTH=40: start base_addr=0, base_num=0; 80 back-to-back words; flush.
//     -> 80 writes, addr 0..79, each a transposed column; no bubble between tiles.
//     -> done 1 cycle after addr 79.
//  2. Partial tile: 43 words then flush.
//     -> tile 2 is padded with 37 zero rows; 80 writes.
//     -> bits 3..39 of every tile-2 output word are 0.
//  3. Wrap: base_addr=500, base_num=7; 40 words.
//     -> addr 500..511 at num 7, then 0..27 at num 8.
//  4. Backpressure: hold out_stall high for 60 cycles while streaming.
//     -> in_ready drops after the second tile is full; no data lost or duplicated.
//     -> ram_we=0 and ram_addr stable while stalled.
//  5. Reset mid-unload (write 10 of tile 1).
//     -> next cycle ram_we=0, busy=0, in_ready=0.
//     -> a new start/40 words yields a clean tile at the new base.
//  6. TRANSPOSE=0, DWIDTH=8: 8 words.
//     -> written unchanged in order, same latency.
//     -> start during busy and flush in IDLE have no effect.

Source files
------------

// File: rtl/swizzle_pkg.sv
// Shared types and defaults for the DRAM-to-CRAM swizzle.
// Holds the FSM state type, default sizes and index-width helper.
package swizzle_pkg;

  localparam int DEF_DWIDTH        = 40;
  localparam int DEF_RAM_AWIDTH    = 9;
  localparam int DEF_RAM_NUM_WORDS = 512;
  localparam int DEF_RAM_NUM_W     = 16;
  localparam int DEF_TRANSPOSE     = 1;

  // Row/column index width for the default tile size.
  localparam int ROW_W = $clog2(DEF_DWIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAD   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // Index width for an n-entry range, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/swizzle_tile_buf.sv
// One DWIDTH x DWIDTH tile of flops.
// Row-wise write port; combinational column (or row) read port.
module swizzle_tile_buf
  import swizzle_pkg::*;
#(
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int TRANSPOSE = DEF_TRANSPOSE,
  parameter int RW        = idx_w(DWIDTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [RW-1:0]     row_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic [RW-1:0]     idx_i,
  output logic [DWIDTH-1:0] data_o
);

  logic [DWIDTH-1:0] mem_q [DWIDTH];

  // Store one incoming word into the addressed row.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[row_i] <= data_i;
    end
  end

  if (TRANSPOSE != 0) begin : g_col
    // Gather column idx_i: bit r comes from row r.
    always_comb begin
      data_o = '0;
      for (int r = 0; r < DWIDTH; r++) begin
        data_o[r] = mem_q[r][idx_i];
      end
    end
  end else begin : g_row
    assign data_o = mem_q[idx_i];
  end

endmodule

// File: rtl/swizzle_d2c_pingpong.sv
// DRAM-to-CRAM swizzle with two ping-pong tile banks.
// Loads DWIDTH words per tile, emits one transposed column per cycle.
module swizzle_d2c_pingpong
  import swizzle_pkg::*;
#(
  parameter int DWIDTH        = DEF_DWIDTH,
  parameter int RAM_AWIDTH    = DEF_RAM_AWIDTH,
  parameter int RAM_NUM_WORDS = DEF_RAM_NUM_WORDS,
  parameter int RAM_NUM_W     = DEF_RAM_NUM_W,
  parameter int TRANSPOSE     = DEF_TRANSPOSE
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [RAM_AWIDTH-1:0] cfg_base_addr_i,
  input  logic [RAM_NUM_W-1:0]  cfg_base_num_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DWIDTH-1:0]     in_data_i,
  input  logic                  flush_i,
  input  logic                  out_stall_i,
  output logic [DWIDTH-1:0]     ram_data_out_o,
  output logic [RAM_AWIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [RAM_NUM_W-1:0]  ram_num_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int RW = idx_w(DWIDTH);
  localparam logic [RW-1:0] LAST_ROW =
    RW'(DWIDTH - 1);
  localparam logic [RAM_AWIDTH-1:0] LAST_ADDR =
    RAM_AWIDTH'(RAM_NUM_WORDS - 1);

  state_e state_q, state_d;

  logic          lb_q, lb_d;
  logic          ub;
  logic [1:0]    full_q, full_d;
  logic [RW-1:0] fill_q, fill_d;
  logic [RW-1:0] col_q, col_d;

  logic              hs;
  logic              pad_wr;
  logic              row_we;
  logic              row_last;
  logic              col_last;
  logic              rd_en;
  logic [DWIDTH-1:0] row_data;
  logic [DWIDTH-1:0] rd0, rd1, rd_data;

  logic [RAM_AWIDTH-1:0] naddr_q, naddr_nx;
  logic [RAM_NUM_W-1:0]  nnum_q, nnum_nx;
  logic [RAM_AWIDTH-1:0] ram_addr_q;
  logic [RAM_NUM_W-1:0]  ram_num_q;
  logic [DWIDTH-1:0]     ram_data_q;
  logic                  ram_we_q;
  logic                  done_q;

  assign ub = ~lb_q;

  assign in_ready_o =
    (state_q == S_RUN) && !full_q[lb_q];
  assign hs       = in_valid_i && in_ready_o;
  assign pad_wr   =
    (state_q == S_PAD) && !full_q[lb_q];
  assign row_we   = hs || pad_wr;
  assign row_data = hs ? in_data_i : '0;
  assign row_last = (fill_q == LAST_ROW);
  assign col_last = (col_q == LAST_ROW);
  assign rd_en    = full_q[ub] && !out_stall_i;
  assign rd_data  = ub ? rd1 : rd0;

  swizzle_tile_buf #(
    .DWIDTH    (DWIDTH),
    .TRANSPOSE (TRANSPOSE),
    .RW        (RW)
  ) u_bank0 (
    .clk_i  (clk_i),
    .we_i   (row_we && !lb_q),
    .row_i  (fill_q),
    .data_i (row_data),
    .idx_i  (col_q),
    .data_o (rd0)
  );

  swizzle_tile_buf #(
    .DWIDTH    (DWIDTH),
    .TRANSPOSE (TRANSPOSE),
    .RW        (RW)
  ) u_bank1 (
    .clk_i  (clk_i),
    .we_i   (row_we && lb_q),
    .row_i  (fill_q),
    .data_i (row_data),
    .idx_i  (col_q),
    .data_o (rd1)
  );

  // Row/column counters, full flags and bank swap.
  // The swap looks at post-update flags so a tile that
  // completes while the other bank drains is handed over
  // on the same edge, keeping both sides bubble-free.
  always_comb begin
    full_d = full_q;
    fill_d = fill_q;
    col_d  = col_q;
    lb_d   = lb_q;
    if (row_we) begin
      fill_d = row_last ? '0 : fill_q + 1'b1;
      if (row_last) begin
        full_d[lb_q] = 1'b1;
      end
    end
    if (rd_en) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        full_d[ub] = 1'b0;
      end
    end
    if (full_d[lb_q] && !full_d[ub]) begin
      lb_d = ub;
    end
  end

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (flush_i) begin
          state_d = (fill_d == '0) ? S_DRAIN : S_PAD;
        end
      end
      S_PAD: begin
        if (row_we && row_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (full_q == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next CRAM address, rolling into the next RAM index.
  always_comb begin
    naddr_nx = naddr_q + 1'b1;
    nnum_nx  = nnum_q;
    if (naddr_q == LAST_ADDR) begin
      naddr_nx = '0;
      nnum_nx  = nnum_q + 1'b1;
    end
  end

  // FSM, bank pointer, flags and counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      lb_q    <= 1'b0;
      full_q  <= 2'b00;
      fill_q  <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      lb_q    <= lb_d;
      full_q  <= full_d;
      fill_q  <= fill_d;
      col_q   <= col_d;
    end
  end

  // Registered CRAM write port and address tracking.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      naddr_q    <= '0;
      nnum_q     <= '0;
      ram_addr_q <= '0;
      ram_num_q  <= '0;
      ram_data_q <= '0;
      ram_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ram_we_q <= rd_en;
      done_q   <= (state_q == S_DRAIN) &&
                  (full_q == 2'b00);
      if ((state_q == S_IDLE) && start_i) begin
        naddr_q <= cfg_base_addr_i;
        nnum_q  <= cfg_base_num_i;
      end
      if (rd_en) begin
        ram_data_q <= rd_data;
        ram_addr_q <= naddr_q;
        ram_num_q  <= nnum_q;
        naddr_q    <= naddr_nx;
        nnum_q     <= nnum_nx;
      end
    end
  end

  assign ram_data_out_o = ram_data_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_num_o      = ram_num_q;
  assign ram_we_o       = ram_we_q;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;

endmodule

// File: tb/tb_swizzle_d2c_pingpong.sv
// Bench for swizzle_d2c_pingpong: tile reference model,
// table of streams, stall, mid-unload reset and bypass mode.
module tb_swizzle_d2c_pingpong;

  localparam int D  = 40;
  localparam int DB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, flush;
  logic        in_valid, out_stall;
  logic [8:0]  cfg_a;
  logic [15:0] cfg_n;
  logic [39:0] in_data;
  logic        in_ready, ram_we, busy, done;
  logic [39:0] ram_data;
  logic [8:0]  ram_addr;
  logic [15:0] ram_num;

  logic        b_start, b_flush, b_valid;
  logic [8:0]  b_cfg_a;
  logic [15:0] b_cfg_n;
  logic [7:0]  b_data_in;
  logic        b_ready, b_we, b_busy, b_done;
  logic [7:0]  b_data;
  logic [8:0]  b_addr;
  logic [15:0] b_num;

  swizzle_d2c_pingpong dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .cfg_base_addr_i (cfg_a),
    .cfg_base_num_i  (cfg_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_data_i       (in_data),
    .flush_i         (flush),
    .out_stall_i     (out_stall),
    .ram_data_out_o  (ram_data),
    .ram_addr_o      (ram_addr),
    .ram_we_o        (ram_we),
    .ram_num_o       (ram_num),
    .busy_o          (busy),
    .done_o          (done)
  );

  swizzle_d2c_pingpong #(
    .DWIDTH    (DB),
    .TRANSPOSE (0)
  ) dut_b (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (b_start),
    .cfg_base_addr_i (b_cfg_a),
    .cfg_base_num_i  (b_cfg_n),
    .in_valid_i      (b_valid),
    .in_ready_o      (b_ready),
    .in_data_i       (b_data_in),
    .flush_i         (b_flush),
    .out_stall_i     (1'b0),
    .ram_data_out_o  (b_data),
    .ram_addr_o      (b_addr),
    .ram_we_o        (b_we),
    .ram_num_o       (b_num),
    .busy_o          (b_busy),
    .done_o          (b_done)
  );

  typedef struct {
    logic [8:0]  a;
    logic [15:0] n;
    logic [39:0] d;
    int          c;
  } wr_t;

  typedef struct {
    logic [8:0]  a;
    logic [15:0] n;
    int          cnt;
    bit          gaps;
    int          exp_w;
    int          last_a;
    int          last_n;
  } vec_t;

  wr_t         wlog[$];
  wr_t         blog[$];
  logic [39:0] sent[$];
  int          cyc = 0;
  int          first_hs, done_cnt, done_cyc;
  int          b_done_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  bit          stall_chk = 0;
  bit          stall_prev = 0;
  logic [8:0]  prev_addr;
  logic [39:0] prev_data;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we)
      wlog.push_back('{ram_addr, ram_num, ram_data, cyc});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (stall_chk && stall_prev) begin
      checks++;
      if (ram_we || ram_addr !== prev_addr ||
          ram_data !== prev_data) begin
        errors++;
        $display("FAIL stall_hold we=%0b addr=%0d need we=0 addr=%0d",
                 ram_we, ram_addr, prev_addr);
      end
    end
    stall_prev = out_stall;
    prev_addr  = ram_addr;
    prev_data  = ram_data;
    if (b_we)
      blog.push_back('{b_addr, b_num, {32'd0, b_data}, cyc});
    if (b_done) b_done_cnt++;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] rnd40();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[39:0];
  endfunction

  task automatic clear_logs();
    wlog.delete();
    sent.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [8:0] a,
                             input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_a = a;
    cfg_n = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [39:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
    end else begin
      if (sent.size() == 0) first_hs = cyc;
      sent.push_back(w);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input logic [8:0] a,
                            input logic [15:0] n,
                            input int cnt, input bit gaps);
    clear_logs();
    pulse_start(a, n);
    for (int i = 0; i < cnt; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      send(rnd40());
    end
    flush_pulse();
    wait_done();
  endtask

  // Model: words grouped in tiles of D, last tile
  // zero-padded; output k = column k%D of tile k/D;
  // addresses linear from base, 512 words per RAM.
  task automatic check_stream(input logic [8:0] a,
                              input logic [15:0] n,
                              input bit timing);
    int nw, exp_w, last;
    nw    = sent.size();
    exp_w = ((nw + D - 1) / D) * D;
    chk("write_count", wlog.size(), exp_w);
    for (int k = 0; k < wlog.size() && k < exp_w; k++) begin
      logic [39:0] ed;
      logic [8:0]  ea;
      logic [15:0] en;
      int          lin;
      for (int r = 0; r < D; r++) begin
        int idx;
        logic [39:0] w;
        idx = (k / D) * D + r;
        if (idx < nw) begin
          w = sent[idx];
          ed[r] = w[k % D];
        end else begin
          ed[r] = 1'b0;
        end
      end
      lin = int'(a) + k;
      ea  = 9'(lin % 512);
      en  = 16'(int'(n) + lin / 512);
      checks++;
      if (wlog[k].d !== ed || wlog[k].a !== ea ||
          wlog[k].n !== en) begin
        errors++;
        $display("FAIL write[%0d] addr=%0d num=%0d data=%h need addr=%0d num=%0d data=%h",
                 k, wlog[k].a, wlog[k].n, wlog[k].d,
                 ea, en, ed);
      end
    end
    chk("done_pulses", done_cnt, 1);
    last = wlog.size() - 1;
    if (exp_w > 0 && last >= 0)
      chk("done_cycle", done_cyc, wlog[last].c + 1);
    if (timing && nw > 0 && nw % D == 0 && last >= 0) begin
      chk("latency", wlog[0].c, first_hs + D + 1);
      chk("no_bubble", wlog[last].c, wlog[0].c + exp_w - 1);
    end
  endtask

  initial begin
    vec_t tbl[6];
    logic [7:0] bw[DB];
    int bhs, n;

    tbl[0] = '{9'd0,   16'd0,     80,  1'b0, 80,  79,  0};
    tbl[1] = '{9'd0,   16'd0,     43,  1'b0, 80,  79,  0};
    tbl[2] = '{9'd500, 16'd7,     40,  1'b0, 40,  27,  8};
    tbl[3] = '{9'd505, 16'hffff,  3,   1'b0, 40,  32,  0};
    tbl[4] = '{9'd100, 16'd3,     0,   1'b0, 0,   0,   0};
    tbl[5] = '{9'd37,  16'd1,     100, 1'b1, 120, 156, 1};

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    in_valid = 1'b0; out_stall = 1'b0;
    cfg_a = '0; cfg_n = '0; in_data = '0;
    b_start = 1'b0; b_flush = 1'b0; b_valid = 1'b0;
    b_cfg_a = '0; b_cfg_n = '0; b_data_in = '0;
    done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_num", ram_num, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_stream(tbl[v].a, tbl[v].n, tbl[v].cnt, tbl[v].gaps);
      chk("tbl_writes", wlog.size(), tbl[v].exp_w);
      if (tbl[v].exp_w > 0 && wlog.size() > 0) begin
        chk("tbl_last_addr", wlog[wlog.size()-1].a, tbl[v].last_a);
        chk("tbl_last_num", wlog[wlog.size()-1].n, tbl[v].last_n);
      end
      check_stream(tbl[v].a, tbl[v].n, !tbl[v].gaps);
    end

    clear_logs();
    stall_chk = 1'b1;
    pulse_start(9'd0, 16'd0);
    fork
      begin
        for (int i = 0; i < 120; i++) send(rnd40());
      end
      begin
        int m = 0;
        while (sent.size() < 30 && m < 300) begin
          @(negedge clk);
          m++;
        end
        @(posedge clk); #1;
        out_stall = 1'b1;
        for (int s = 0; s < 60; s++) begin
          @(posedge clk); #1;
          if (s == 55) chk("ready_low_stalled", in_ready, 0);
        end
        out_stall = 1'b0;
      end
    join
    flush_pulse();
    wait_done();
    stall_chk = 1'b0;
    check_stream(9'd0, 16'd0, 1'b0);

    clear_logs();
    pulse_start(9'd0, 16'd0);
    for (int i = 0; i < D; i++) send(rnd40());
    n = 0;
    while (wlog.size() < 11 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_write10", wlog.size() >= 11, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_we", ram_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    reset = 1'b0;
    run_stream(9'd200, 16'd2, D, 1'b0);
    check_stream(9'd200, 16'd2, 1'b1);

    blog.delete();
    b_done_cnt = 0;
    b_flush = 1'b1;
    @(posedge clk); #1;
    b_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b_idle_flush_busy", b_busy, 0);
    chk("b_idle_flush_writes", blog.size(), 0);
    chk("b_idle_flush_done", b_done_cnt, 0);
    b_start = 1'b1; b_cfg_a = 9'd20; b_cfg_n = 16'd5;
    @(posedge clk); #1;
    b_start = 1'b0;
    chk("b_busy", b_busy, 1);
    bhs = 0;
    for (int i = 0; i < DB; i++) begin
      int m = 0;
      bw[i] = 8'($urandom);
      b_valid = 1'b1;
      b_data_in = bw[i];
      if (i == 3) begin
        b_start = 1'b1; b_cfg_a = 9'd300; b_cfg_n = 16'd9;
      end
      @(negedge clk);
      while (!b_ready && m < 50) begin
        @(negedge clk);
        m++;
      end
      if (!b_ready) chk("b_send_timeout", 0, 1);
      if (i == 0) bhs = cyc;
      @(posedge clk); #1;
      b_valid = 1'b0;
      b_start = 1'b0;
    end
    b_flush = 1'b1;
    @(posedge clk); #1;
    b_flush = 1'b0;
    n = 0;
    while (b_done_cnt == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("b_writes", blog.size(), DB);
    chk("b_done_pulses", b_done_cnt, 1);
    for (int k = 0; k < blog.size() && k < DB; k++) begin
      chk("b_data", blog[k].d, {32'd0, bw[k]});
      chk("b_addr", blog[k].a, 20 + k);
      chk("b_num", blog[k].n, 5);
    end
    if (blog.size() > 0)
      chk("b_latency", blog[0].c, bhs + DB + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
